// File: rtl/imm_decode_pkg.sv
// Shared types and constants for the immediate decode stage.
// Optional feature macro: IMM_ILLEGAL_DETECT_EN adds an illegal flag to each entry.
package imm_decode_pkg;

    localparam int INSTR_W    = 32;
    localparam int IMM_W      = 12;
    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4
    } fmt_e;

    // One decoded instruction as held in the main or skid register.
    typedef struct packed {
        logic [IMM_W-1:0]      imm;
        fmt_e                  fmt;
        logic [2:0]            funct3;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
`ifdef IMM_ILLEGAL_DETECT_EN
        logic                  illegal;
`endif
    } dec_entry_t;

endpackage

// File: rtl/imm_field_extract.sv
// Combinational field extraction: opcode selects the format and how the
// 12-bit immediate is gathered; register indices and funct3 are fixed slices.
// Optional feature macro: IMM_ILLEGAL_DETECT_EN adds the illegal output.
module imm_field_extract
    import imm_decode_pkg::*;
(
    input  logic [INSTR_W-1:0]    instr,
    output logic [IMM_W-1:0]      imm,
    output logic [2:0]            fmt,
    output logic [2:0]            funct3,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2
`ifdef IMM_ILLEGAL_DETECT_EN
    ,
    output logic                  illegal
`endif
);

    assign funct3 = instr[14:12];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    // Opcode decode into format and raw immediate; unknown opcodes give NONE/0.
    always_comb begin
        imm = '0;
        fmt = FMT_NONE;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                imm = instr[31:20];
                fmt = FMT_I;
            end
            OPC_STORE: begin
                imm = {instr[31:25], instr[11:7]};
                fmt = FMT_S;
            end
            OPC_BRANCH: begin
                // Branch offset bits [12:1]; bit 0 is implicitly zero.
                imm = {instr[31], instr[7], instr[30:25], instr[11:8]};
                fmt = FMT_B;
            end
            OPC_OP: begin
                imm = '0;
                fmt = FMT_R;
            end
            default: begin
                imm = '0;
                fmt = FMT_NONE;
            end
        endcase
    end

`ifdef IMM_ILLEGAL_DETECT_EN
    // Every listed opcode ends in 2'b11, so an unlisted opcode covers both cases.
    assign illegal = (fmt == FMT_NONE) || (instr[1:0] != 2'b11);
`endif

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate decode stage with a two-entry skid buffer
// (main + skid register) on a valid/ready handshake.
// Optional feature macro: IMM_ILLEGAL_DETECT_EN adds the out_illegal port.
module imm_decode_stage
    import imm_decode_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_W-1:0]    in_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IMM_W-1:0]      out_imm,
    output logic [2:0]            out_fmt,
    output logic [2:0]            out_funct3,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [REG_ADDR_W-1:0] out_rs1,
    output logic [REG_ADDR_W-1:0] out_rs2
`ifdef IMM_ILLEGAL_DETECT_EN
    ,
    output logic                  out_illegal
`endif
);

    dec_entry_t main_q;
    dec_entry_t skid_q;
    dec_entry_t new_entry;
    logic       main_valid;
    logic       skid_valid;
    logic       accept;
    logic       main_free;

    logic [IMM_W-1:0]      x_imm;
    logic [2:0]            x_fmt;
    logic [2:0]            x_funct3;
    logic [REG_ADDR_W-1:0] x_rd;
    logic [REG_ADDR_W-1:0] x_rs1;
    logic [REG_ADDR_W-1:0] x_rs2;
`ifdef IMM_ILLEGAL_DETECT_EN
    logic                  x_illegal;
`endif

    imm_field_extract u_extract (
        .instr   (in_instr),
        .imm     (x_imm),
        .fmt     (x_fmt),
        .funct3  (x_funct3),
        .rd      (x_rd),
        .rs1     (x_rs1),
        .rs2     (x_rs2)
`ifdef IMM_ILLEGAL_DETECT_EN
        ,
        .illegal (x_illegal)
`endif
    );

    // Pack the extracted fields of the incoming instruction into one entry.
    always_comb begin
        new_entry        = '0;
        new_entry.imm    = x_imm;
        new_entry.fmt    = fmt_e'(x_fmt);
        new_entry.funct3 = x_funct3;
        new_entry.rd     = x_rd;
        new_entry.rs1    = x_rs1;
        new_entry.rs2    = x_rs2;
`ifdef IMM_ILLEGAL_DETECT_EN
        new_entry.illegal = x_illegal;
`endif
    end

    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready;
    // Main can take a new value when it is empty or its entry leaves this cycle.
    assign main_free = !main_valid || out_ready;

    // Skid buffer update: reset beats flush, flush beats accept and transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                // in_ready is low while skid is full, so no accept competes here.
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= new_entry;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= new_entry;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid  = main_valid;
    assign out_imm    = main_q.imm;
    assign out_fmt    = main_q.fmt;
    assign out_funct3 = main_q.funct3;
    assign out_rd     = main_q.rd;
    assign out_rs1    = main_q.rs1;
    assign out_rs2    = main_q.rs2;
`ifdef IMM_ILLEGAL_DETECT_EN
    assign out_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: directed cases followed by random
// traffic, compared against a two-deep FIFO reference holding decoded entries.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_imm;
    logic [2:0]  out_fmt;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
`ifdef IMM_ILLEGAL_DETECT_EN
    logic        out_illegal;
`endif

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    typedef struct {
        int imm;
        int fmt;
        int funct3;
        int rd;
        int rs1;
        int rs2;
        int illegal;
    } exp_t;

    exp_t model_q[$];

    always #5 clk = ~clk;

    imm_decode_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_imm    (out_imm),
        .out_fmt    (out_fmt),
        .out_funct3 (out_funct3),
        .out_rd     (out_rd),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2)
`ifdef IMM_ILLEGAL_DETECT_EN
        ,
        .out_illegal(out_illegal)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode from the format rules, using shifts and masks on an integer.
    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t e;
        longint unsigned w = ins;
        int opc = int'(w & 64'h7F);
        e.funct3 = int'((w >> 12) & 7);
        e.rd     = int'((w >> 7) & 31);
        e.rs1    = int'((w >> 15) & 31);
        e.rs2    = int'((w >> 20) & 31);
        e.imm    = 0;
        e.fmt    = 0;
        if (opc == 'h13 || opc == 'h03 || opc == 'h67) begin
            e.fmt = 2;
            e.imm = int'((w >> 20) & 'hFFF);
        end else if (opc == 'h23) begin
            e.fmt = 3;
            e.imm = int'((((w >> 25) & 'h7F) * 32) + ((w >> 7) & 31));
        end else if (opc == 'h63) begin
            e.fmt = 4;
            e.imm = int'((((w >> 31) & 1) * 2048) + (((w >> 7) & 1) * 1024)
                       + (((w >> 25) & 63) * 16) + ((w >> 8) & 15));
        end else if (opc == 'h33) begin
            e.fmt = 1;
        end
        e.illegal = (e.fmt == 0 || (w & 3) != 3) ? 1 : 0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int sel;
        w   = $urandom;
        sel = $urandom_range(0, 7);
        case (sel)
            0: w[6:0] = 7'h13;
            1: w[6:0] = 7'h03;
            2: w[6:0] = 7'h67;
            3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h33;
            default: ;
        endcase
        return w;
    endfunction

    // Called at a falling edge: compare outputs, drive inputs, advance one clock.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy,
                         input logic fl, input logic rs);
        logic acc;
        logic xf;
        chk("out_valid", out_valid, model_q.size() > 0);
        chk("in_ready", in_ready, model_q.size() < 2);
        if (model_q.size() > 0) begin
            chk("imm", out_imm, model_q[0].imm);
            chk("fmt", out_fmt, model_q[0].fmt);
            chk("funct3", out_funct3, model_q[0].funct3);
            chk("rd", out_rd, model_q[0].rd);
            chk("rs1", out_rs1, model_q[0].rs1);
            chk("rs2", out_rs2, model_q[0].rs2);
`ifdef IMM_ILLEGAL_DETECT_EN
            chk("illegal", out_illegal, model_q[0].illegal);
`endif
        end
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        rst_n     = !rs;
        acc = v && (model_q.size() < 2);
        xf  = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (rs || fl) begin
            model_q.delete();
        end else begin
            if (xf) begin
                void'(model_q.pop_front());
                xfers++;
            end
            if (acc) model_q.push_back(ref_decode(ins));
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_imm", out_imm, 0);
        chk("rst_fmt", out_fmt, 0);
        chk("rst_funct3", out_funct3, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_rs1", out_rs1, 0);
        chk("rst_rs2", out_rs2, 0);
`ifdef IMM_ILLEGAL_DETECT_EN
        chk("rst_illegal", out_illegal, 0);
`endif
    endtask

    initial begin
        int start_xfers;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h8011_0093;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();

        // I-type, with the sign-extended view the downstream extender sees.
        cycle(1, 32'h8011_0093, 1, 0, 0);
        chk("i_imm", out_imm, 12'h801);
        chk("i_fmt", out_fmt, 3'd2);
        chk("i_sext", {{20{out_imm[11]}}, out_imm}, 32'hFFFF_F801);
        // S-type
        cycle(1, 32'h7653_28A3, 1, 0, 0);
        chk("s_imm", out_imm, 12'h771);
        chk("s_fmt", out_fmt, 3'd3);
        chk("s_funct3", out_funct3, 3'd2);
        // B-type
        cycle(1, 32'hD400_0A63, 1, 0, 0);
        chk("b_imm", out_imm, 12'hAAA);
        chk("b_fmt", out_fmt, 3'd4);
        // R-type
        cycle(1, 32'h00B5_0533, 1, 0, 0);
        chk("r_imm", out_imm, 12'h000);
        chk("r_fmt", out_fmt, 3'd1);
        // Unknown opcode
        cycle(1, 32'hFFFF_FFFF, 1, 0, 0);
        chk("none_fmt", out_fmt, 3'd0);
`ifdef IMM_ILLEGAL_DETECT_EN
        chk("none_illegal", out_illegal, 1);
`endif
        cycle(0, 32'h0, 1, 0, 0);

        // Back-pressure: A to main, B to skid, C refused, then drain in order.
        cycle(1, 32'h0010_0093, 0, 0, 0);
        cycle(1, 32'h0020_0093, 0, 0, 0);
        cycle(1, 32'h0030_0093, 0, 0, 0);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_head_imm", out_imm, 12'h001);
        start_xfers = xfers;
        cycle(1, 32'h0030_0093, 1, 0, 0);
        chk("bp_second_imm", out_imm, 12'h002);
        cycle(1, 32'h0030_0093, 1, 0, 0);
        chk("bp_third_imm", out_imm, 12'h003);
        cycle(0, 32'h0, 1, 0, 0);
        cycle(0, 32'h0, 1, 0, 0);
        chk("bp_xfer_count", xfers - start_xfers, 3);

        // Flush with both registers full and an input offered.
        cycle(1, 32'h0040_0093, 0, 0, 0);
        cycle(1, 32'h0050_0093, 0, 0, 0);
        cycle(1, 32'h0060_0093, 0, 1, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        // Flush while accepting into an empty stage drops the input.
        cycle(1, 32'h0070_0093, 1, 1, 0);
        chk("flush_drop_valid", out_valid, 0);

        // Reset with both registers full.
        cycle(1, 32'h0080_0093, 0, 0, 0);
        cycle(1, 32'h0090_0093, 0, 0, 0);
        cycle(1, 32'h00A0_0093, 0, 0, 1);
        chk_reset_outputs();

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
        end
        cycle(0, 32'h0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Registered decode stage directly upstream of the 12→32 sign extender.
- Accepts 32-bit RV32I instructions over a valid/ready handshake and extracts the 12-bit immediate field per instruction format (I/S/B).
- Presents that field, plus register indices, funct3 and format code, one cycle later.
- A 2-entry skid buffer (main + skid register) gives full throughput under back-pressure.

Parameters:
- INSTR_W, 32, instruction width.
- IMM_W, 12, extracted immediate width; feeds the sign extender input.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; equals NOT skid_valid.
- in_instr  in  INSTR_W  instruction word.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  IMM_W  raw 12-bit immediate field (not sign-extended).
- out_fmt  out  3  format: 0 NONE, 1 R, 2 I, 3 S, 4 B.
- out_funct3  out  3  instr[14:12].
- out_rd  out  REG_ADDR_W  instr[11:7].
- out_rs1  out  REG_ADDR_W  instr[19:15].
- out_rs2  out  REG_ADDR_W  instr[24:20].

Interface note (already decided): one clock, clk; reset rst_n is synchronous and active-low.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - main_valid = skid_valid = 0.
  - out_valid=0, in_ready=1.
  - out_imm, out_fmt, out_funct3, out_rd, out_rs1, out_rs2 all 0.
  - Reset mid-transfer discards both entries; in_valid is ignored while rst_n=0.
- Extraction by opcode instr[6:0]:
  - 0010011, 0000011, 1100111 → I: imm = instr[31:20].
  - 0100011 → S: imm = {instr[31:25], instr[11:7]}.
  - 1100011 → B: imm = {instr[31], instr[7], instr[30:25], instr[11:8]}, i.e. offset bits [12:1].
  - 0110011 → R: imm = 0.
  - Any other opcode → NONE: imm = 0.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Latency: accept at edge N → out_valid=1 after edge N (1 cycle) when the main register is empty or draining.
- Skid rules:
  - Main register holds when out_valid && !out_ready.
  - An accept while the main register holds writes the skid register; in_ready then drops the next cycle.
  - On drain, skid moves to main, skid_valid clears, and in_ready reasserts the following cycle.
- Ordering: strict FIFO; no entry is lost or duplicated.
- Simultaneous transfer and accept with skid empty: main takes the new entry and out_valid stays 1.
- Output stability: outputs stay stable while out_valid && !out_ready.
- Flush:
  - Clears main_valid and skid_valid at the edge.
  - An input accepted in the same cycle as flush is dropped.
  - flush has priority over accept and transfer; rst_n has priority over flush.
  - Data registers need not clear on flush.

Optional Feature:
- Macro: IMM_ILLEGAL_DETECT_EN.
- Defined:
  - Adds output port out_illegal (1 bit), registered alongside the other outputs.
  - out_illegal=1 when the opcode is in none of the listed groups or instr[1:0]≠11; out_fmt is then NONE.
  - out_illegal resets to 0.
- Undefined: port absent; unknown opcodes decode silently as NONE with imm=0.

Decomposition:
- Package imm_decode_pkg holds:
  - opcode constants OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_OP.
  - format enum FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B (3 bits).
  - a struct bundling imm/fmt/funct3/rd/rs1/rs2 (main and skid registers are of this type).
- Sub-module imm_field_extract: purely combinational opcode → {imm, fmt} decode, instantiated once on in_instr.
- The top level holds the skid/handshake logic.

Test Plan:
- I-type: in_instr=0x80110093 (addi x1,x2,-2047), out_ready=1 → after 1 cycle out_imm=0x801, out_fmt=2, rd=1, rs1=2; downstream extender sees 0xFFFFF801.
- S-type: 0x765328A3 (sw x5,0x771(x6)) → out_imm=0x771, fmt=3, rs1=6, rs2=5, funct3=2.
- B-type: 0xD4000A63 → out_imm=0xAAA, fmt=4. R-type 0x00B50533 → out_imm=0x000, fmt=1.
- Back-pressure: out_ready=0 for 3 cycles while A, B, C are offered →
  - A held in main, B in skid, in_ready=0, C not accepted.
  - On out_ready=1: A, B, C are delivered in order, none lost or duplicated.
- Flush with main and skid full, plus in_valid=1 the same cycle → next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears.
- Reset asserted with both registers full → out_valid=0, all outputs 0, in_ready=1. With IMM_ILLEGAL_DETECT_EN defined, opcode 0x7F yields out_illegal=1, fmt=0.
